alu_op_issue: RTL
=================

Name: alu_op_issue

Overview:
- Decode/issue stage that converts 32-bit MIPS instruction words into the 6-bit ALU op code plus operand controls consumed by the execute-stage ALU.
- Sits between fetch and execute. Uses valid/ready handshakes on both sides.
- Has a 2-entry skid buffer, so the input ready is a register output and never combinationally depends on out_ready.

Parameters:
- DEPTH, 2, skid entries; only 2 is supported.
- RESET_PC_TAG, 32'h0, value reset into the pc_out register.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  instruction word.
- in_pc  in  32  PC of the instruction.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  execute accepts the entry.
- alu_op  out  6  ALU op code.
- sa  out  5  shift amount, instr[10:6].
- imm32  out  32  extended immediate.
- alusrc  out  1  1 = ALU b operand comes from imm32.
- wreg  out  5  destination register (rd for R-type, rt for I-type).
- reg_write  out  1  instruction writes the register file.
- mem_read  out  1  load.
- mem_write  out  1  store.
- ovf_chk  out  1  add/addi overflow-trap enable.
- illegal  out  1  unsupported encoding.
- pc_out  out  32  PC of the entry currently on the output.

Behaviour:
- Reset: every output is 0 except in_ready=1 and pc_out=RESET_PC_TAG. Both skid entries are invalid.
- Op codes (package constants):
  - NOP 000000
  - OR 000100
  - NOR 000101
  - XOR 000110
  - AND 000111
  - SLL 001000
  - SRL 001001
  - LUI 001010
  - ADD 010001
  - SRA 011001
  - SLLV 101000
  - SRLV 101001
  - SRAV 111001
- R-type decode (opcode 000000), by funct:
  - 100000 add → ADD, ovf_chk=1.
  - 100001 addu → ADD.
  - 100100 → AND; 100101 → OR; 100110 → XOR; 100111 → NOR.
  - 000000 → SLL; 000010 → SRL; 000011 → SRA.
  - 000100 → SLLV; 000110 → SRLV; 000111 → SRAV.
  - All of the above: reg_write=1, wreg=rd, alusrc=0.
  - Exception: instr==0 is NOP with reg_write=0.
- I-type decode, all with alusrc=1 and wreg=rt:
  - addi 001000 → ADD, sign-extended imm, ovf_chk=1.
  - addiu 001001 → ADD, sign-extended imm.
  - andi 001100 → AND, zero-extended imm.
  - ori 001101 → OR, zero-extended imm.
  - xori 001110 → XOR, zero-extended imm.
  - lui 001111 → LUI, imm32 = zero-extended imm.
  - lw 100011 → ADD, sign-extended imm, mem_read=1, reg_write=1.
  - sw 101011 → ADD, sign-extended imm, mem_write=1, reg_write=0.
- Any other encoding: illegal=1, alu_op=NOP, reg_write/mem_read/mem_write all 0. The entry still issues normally.
- Latency: decode happens at accept. An instruction accepted in cycle N is presented on the outputs with out_valid=1 in cycle N+1 when the buffer was empty.
- Transfer rules:
  - Input transfer happens iff in_valid && in_ready.
  - Output transfer happens iff out_valid && out_ready.
  - All outputs stay stable while out_valid && !out_ready.
- Buffer states:
  - EMPTY → ONE on accept.
  - ONE → TWO on accept without drain.
  - ONE → EMPTY on drain without accept.
  - ONE stays ONE on simultaneous accept and drain.
  - TWO → ONE on drain; in TWO, in_ready=0.
  - in_ready is registered and equals 1 in EMPTY and ONE.
- Order: first-in first-out; the second entry moves to the output on drain.
- flush: next state EMPTY and out_valid=0. An accept in the same cycle is discarded; flush has priority. in_ready=1 on the following cycle.
- resetn asserted mid-transfer: immediate return to the reset state and all entries are lost.

Optional Feature:
- Macro ALU_OP_ISSUE_PERF_EN.
- When defined:
  - Adds output ports issued_cnt[31:0] and illegal_cnt[31:0].
  - issued_cnt increments on each output transfer; illegal_cnt increments on each output transfer with illegal=1.
  - Both counters are cleared by resetn (not by flush) and wrap from 32'hFFFFFFFF to 0.
- When undefined: no ports and no counter logic.

Decomposition:
- Package alu_op_pkg holds:
  - the 6-bit ALU op constants;
  - opcode/funct constants;
  - a packed decoded-entry struct {alu_op, sa, imm32, alusrc, wreg, reg_write, mem_read, mem_write, ovf_chk, illegal, pc}.
- One sub-module, alu_op_dec: purely combinational instr → entry decode, instantiated once at the input.
- The top level holds the skid FSM and the registers.

Test Plan:
- Reset check: assert resetn=0 → in_ready=1, out_valid=0, pc_out=RESET_PC_TAG.
- Decode check: in_instr=32'h3C011234 (lui $1,0x1234) → next cycle:
  - alu_op=001010, imm32=32'h00001234;
  - alusrc=1, wreg=1, reg_write=1.
- R-type and shift checks:
  - in_instr=32'h00432020 (add $4,$2,$3) → alu_op=010001, wreg=4, ovf_chk=1.
  - in_instr=32'h00021883 (sra $3,$2,2) → alu_op=011001, sa=2.
- Backpressure: hold out_ready=0 and send 3 instructions →
  - accept 2, then in_ready=0;
  - outputs stable;
  - release out_ready → entries drain in order with correct pc_out.
- Illegal and store: in_instr=32'hFC000000 → illegal=1, alu_op=000000, reg_write=0. sw 32'hAC220008 → alu_op=010001, imm32=8, mem_write=1.
- Flush: flush with TWO entries held and in_valid=1 → out_valid=0 next cycle, in_ready=1, and the simultaneously offered instruction never appears. With ALU_OP_ISSUE_PERF_EN, issued_cnt is unchanged by the flush.

Source files
------------

// File: rtl/alu_op_pkg.sv
// rtl/alu_op_pkg.sv - ALU op codes, MIPS opcode/funct constants and decoded-entry type
package alu_op_pkg;

  localparam logic [5:0] ALU_NOP  = 6'b000000;
  localparam logic [5:0] ALU_OR   = 6'b000100;
  localparam logic [5:0] ALU_NOR  = 6'b000101;
  localparam logic [5:0] ALU_XOR  = 6'b000110;
  localparam logic [5:0] ALU_AND  = 6'b000111;
  localparam logic [5:0] ALU_SLL  = 6'b001000;
  localparam logic [5:0] ALU_SRL  = 6'b001001;
  localparam logic [5:0] ALU_LUI  = 6'b001010;
  localparam logic [5:0] ALU_ADD  = 6'b010001;
  localparam logic [5:0] ALU_SRA  = 6'b011001;
  localparam logic [5:0] ALU_SLLV = 6'b101000;
  localparam logic [5:0] ALU_SRLV = 6'b101001;
  localparam logic [5:0] ALU_SRAV = 6'b111001;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;

  typedef struct packed {
    logic [5:0]  alu_op;
    logic [4:0]  sa;
    logic [31:0] imm32;
    logic        alusrc;
    logic [4:0]  wreg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        ovf_chk;
    logic        illegal;
    logic [31:0] pc;
  } dec_entry_t;

endpackage

// File: rtl/alu_op_dec.sv
// rtl/alu_op_dec.sv - combinational MIPS instruction word to decoded-entry translation
module alu_op_dec
  import alu_op_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output dec_entry_t  entry_o
);

  logic [5:0]  opc;
  logic [5:0]  fn;
  logic [31:0] sext;
  logic [31:0] zext;

  assign opc  = instr_i[31:26];
  assign fn   = instr_i[5:0];
  assign sext = {{16{instr_i[15]}}, instr_i[15:0]};
  assign zext = {16'h0, instr_i[15:0]};

  always_comb begin
    entry_o    = '0;
    entry_o.sa = instr_i[10:6];
    entry_o.pc = pc_i;
    // The all-zero word is the canonical NOP, not "sll $0,$0,0".
    if (instr_i == 32'h0) begin
      entry_o.alu_op = ALU_NOP;
    end else if (opc == OPC_RTYPE) begin
      entry_o.wreg      = instr_i[15:11];
      entry_o.reg_write = 1'b1;
      case (fn)
        FN_ADD:  begin entry_o.alu_op = ALU_ADD; entry_o.ovf_chk = 1'b1; end
        FN_ADDU: entry_o.alu_op = ALU_ADD;
        FN_AND:  entry_o.alu_op = ALU_AND;
        FN_OR:   entry_o.alu_op = ALU_OR;
        FN_XOR:  entry_o.alu_op = ALU_XOR;
        FN_NOR:  entry_o.alu_op = ALU_NOR;
        FN_SLL:  entry_o.alu_op = ALU_SLL;
        FN_SRL:  entry_o.alu_op = ALU_SRL;
        FN_SRA:  entry_o.alu_op = ALU_SRA;
        FN_SLLV: entry_o.alu_op = ALU_SLLV;
        FN_SRLV: entry_o.alu_op = ALU_SRLV;
        FN_SRAV: entry_o.alu_op = ALU_SRAV;
        default: begin
          entry_o.illegal   = 1'b1;
          entry_o.wreg      = '0;
          entry_o.reg_write = 1'b0;
        end
      endcase
    end else begin
      entry_o.alusrc    = 1'b1;
      entry_o.wreg      = instr_i[20:16];
      entry_o.reg_write = 1'b1;
      entry_o.imm32     = sext;
      entry_o.alu_op    = ALU_ADD;
      case (opc)
        OPC_ADDI:  entry_o.ovf_chk = 1'b1;
        OPC_ADDIU: entry_o.ovf_chk = 1'b0;
        OPC_ANDI:  begin entry_o.alu_op = ALU_AND; entry_o.imm32 = zext; end
        OPC_ORI:   begin entry_o.alu_op = ALU_OR;  entry_o.imm32 = zext; end
        OPC_XORI:  begin entry_o.alu_op = ALU_XOR; entry_o.imm32 = zext; end
        OPC_LUI:   begin entry_o.alu_op = ALU_LUI; entry_o.imm32 = zext; end
        OPC_LW:    entry_o.mem_read = 1'b1;
        OPC_SW:    begin entry_o.mem_write = 1'b1; entry_o.reg_write = 1'b0; end
        default: begin
          entry_o.alu_op    = ALU_NOP;
          entry_o.illegal   = 1'b1;
          entry_o.alusrc    = 1'b0;
          entry_o.wreg      = '0;
          entry_o.reg_write = 1'b0;
          entry_o.imm32     = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - decode/issue stage with a 2-entry skid buffer
// Optional ALU_OP_ISSUE_PERF_EN adds issued_cnt/illegal_cnt transfer counters.
module alu_op_issue
  import alu_op_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  alu_op,
  output logic [4:0]  sa,
  output logic [31:0] imm32,
  output logic        alusrc,
  output logic [4:0]  wreg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ovf_chk,
  output logic        illegal,
  output logic [31:0] pc_out
`ifdef ALU_OP_ISSUE_PERF_EN
  ,
  output logic [31:0] issued_cnt,
  output logic [31:0] illegal_cnt
`endif
);

  // State value equals buffer occupancy.
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = OCC_W'(0),
    ST_ONE   = OCC_W'(1),
    ST_TWO   = OCC_W'(2)
  } state_t;

  state_t     state_q;
  dec_entry_t dec_e;
  dec_entry_t head_q;
  dec_entry_t skid_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       acc;
  logic       drn;

  alu_op_dec u_dec (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .entry_o (dec_e)
  );

  assign acc = in_valid & in_ready_q;
  assign drn = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      head_q.pc   <= RESET_PC_TAG;
      skid_q      <= '0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) begin
          head_q      <= dec_e;
          out_valid_q <= 1'b1;
          state_q     <= ST_ONE;
        end
        ST_ONE: begin
          if (acc && !drn) begin
            skid_q     <= dec_e;
            in_ready_q <= 1'b0;
            state_q    <= ST_TWO;
          end else if (acc) begin
            head_q <= dec_e;
          end else if (drn) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_TWO: if (drn) begin
          head_q     <= skid_q;
          in_ready_q <= 1'b1;
          state_q    <= ST_ONE;
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign alu_op    = head_q.alu_op;
  assign sa        = head_q.sa;
  assign imm32     = head_q.imm32;
  assign alusrc    = head_q.alusrc;
  assign wreg      = head_q.wreg;
  assign reg_write = head_q.reg_write;
  assign mem_read  = head_q.mem_read;
  assign mem_write = head_q.mem_write;
  assign ovf_chk   = head_q.ovf_chk;
  assign illegal   = head_q.illegal;
  assign pc_out    = head_q.pc;

`ifdef ALU_OP_ISSUE_PERF_EN
  logic [31:0] issued_cnt_q;
  logic [31:0] illegal_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issued_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else if (drn) begin
      issued_cnt_q <= issued_cnt_q + 32'd1;
      if (head_q.illegal) illegal_cnt_q <= illegal_cnt_q + 32'd1;
    end
  end

  assign issued_cnt  = issued_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule
